phase_parser: RTL and testbench

- Per-channel phase register for the transducer array.
- A shared 16-bit command word is broadcast on `phase_data` to one instance per channel, created in a generate loop with `CHANNEL` = loop index.
- Each instance watches the address byte. When `en` is high and the address equals its `CHANNEL`, it latches the phase byte and holds it on `phase` for the downstream PWM/phase generator.

---
 rtl/phase_parser.sv | 77 +++++++
 tb/tb_phase_parser.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/phase_parser.sv
// -----------------------------------------------------------------------------
// phase_parser
//
// Per-channel phase register for the transducer array. One instance exists
// for each channel, and every instance sees the same broadcast command word.
// An instance latches the phase byte when the word is qualified by en and the
// address byte equals its CHANNEL. It then holds that byte on phase for the
// downstream PWM/phase generator.
//
// Parameters:
//   CHANNEL     channel address this instance answers to. Legal range is
//               0..255, or 0..254 when broadcast support is compiled in.
//
// Ports:
//   clk         system clock; all state updates happen on its rising edge
//   rst         synchronous, active-high reset; clears phase to 8'h00
//   en          command-valid qualifier for phase_data
//   phase_data  command word: [15:8] channel address, [7:0] phase value
//   phase       registered phase value for this channel
//
// Optional feature (compile-time macro PHASE_PARSER_BROADCAST_EN):
//   When this macro is defined, address 8'hFF becomes a broadcast address.
//   A broadcast word loads every instance, and CHANNEL 255 is rejected at
//   elaboration. When it is undefined, 8'hFF is an ordinary address that
//   only the CHANNEL==255 instance matches.
// -----------------------------------------------------------------------------
module phase_parser #(
  parameter int CHANNEL = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] phase_data,
  output logic [7:0]  phase
);

  localparam logic [7:0] ADDR      = 8'(CHANNEL);
  localparam logic [7:0] BCAST_ADR = 8'hFF;

  logic [7:0] cmd_addr;
  logic [7:0] cmd_phase;
  logic       addr_hit;
  logic       load;

  assign cmd_addr  = phase_data[15:8];
  assign cmd_phase = phase_data[7:0];
  assign addr_hit  = (cmd_addr == ADDR);

`ifdef PHASE_PARSER_BROADCAST_EN
  // 8'hFF is reserved as the broadcast address, so no instance may claim it
  // as its own channel.
  if (CHANNEL < 0 || CHANNEL > 254) begin : g_bad_channel
    $error("phase_parser: CHANNEL %0d out of range 0..254 with broadcast enabled", CHANNEL);
  end

  assign load = en && (addr_hit || (cmd_addr == BCAST_ADR));
`else
  if (CHANNEL < 0 || CHANNEL > 255) begin : g_bad_channel
    $error("phase_parser: CHANNEL %0d out of range 0..255", CHANNEL);
  end

  assign load = en && addr_hit;
`endif

  // Phase register. Reset has priority over any command. The register only
  // changes on a qualified, matching word; otherwise it holds its value.
  // The output comes straight from this flop, so there is no combinational
  // path from the inputs to phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 8'h00;
    end else if (load) begin
      phase <= cmd_phase;
    end
  end

endmodule

// File: tb/tb_phase_parser.sv
// -----------------------------------------------------------------------------
// tb_phase_parser
//
// This bench instantiates five phase_parser channels: 0..3, plus a top
// channel. The top channel is 255 when broadcast is disabled and 254 when it
// is enabled. The bench drives directed and random command words.
//
// For every driven cycle, a reference model of the register array predicts
// the phase of every channel and pushes that prediction into a queue. A
// separate monitor pops each prediction on the following falling edge and
// compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_phase_parser;

  localparam int NCH = 5;
`ifdef PHASE_PARSER_BROADCAST_EN
  localparam int LAST_CH   = 254;
  localparam bit BCAST_ON  = 1'b1;
`else
  localparam int LAST_CH   = 255;
  localparam bit BCAST_ON  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic [15:0] phase_data = 16'h0000;
  logic [7:0]  phase_out [NCH];

  int total = 0;
  int bad   = 0;

  // Reference state: the predicted phase per channel, indexed like the
  // instances below.
  int         chan_addr [NCH];
  logic [7:0] model_phase [NCH];
  logic [NCH-1:0][7:0] exp_q [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    phase_parser #(.CHANNEL((g < 4) ? g : LAST_CH)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .phase_data (phase_data),
      .phase      (phase_out[g])
    );
  end

  // Drive one cycle of inputs on the falling edge. After the rising edge,
  // apply the register rules to the model and queue the expected outputs.
  task automatic applyStimulus(input logic r, input logic e, input logic [15:0] d);
    logic [NCH-1:0][7:0] snap;
    @(negedge clk);
    rst        = r;
    en         = e;
    phase_data = d;
    @(posedge clk);
    for (int i = 0; i < NCH; i++) begin
      if (r)
        model_phase[i] = 8'h00;
      else if (e && (int'(d[15:8]) == chan_addr[i] || (BCAST_ON && d[15:8] == 8'hFF)))
        model_phase[i] = d[7:0];
      snap[i] = model_phase[i];
    end
    exp_q.push_back(snap);
  endtask

  task automatic checkOutput(input logic [NCH-1:0][7:0] expv);
    for (int i = 0; i < NCH; i++) begin
      total++;
      if (phase_out[i] !== expv[i]) begin
        bad++;
        $display("[TB] FAIL ch%0d phase: got %02h expected %02h at %0t",
                 chan_addr[i], phase_out[i], expv[i], $time);
      end
    end
  endtask

  // Monitor: one prediction is consumed per falling edge that has one
  // pending.
  initial begin
    logic [NCH-1:0][7:0] expv;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        checkOutput(expv);
      end
    end
  end

  initial begin
    logic [7:0] a;
    for (int i = 0; i < NCH; i++) begin
      chan_addr[i]   = (i < 4) ? i : LAST_CH;
      model_phase[i] = 8'h00;
    end

    // Reset: held for two cycles while a matching word is enabled.
    applyStimulus(1'b1, 1'b1, 16'h0101);
    applyStimulus(1'b1, 1'b1, 16'h0101);

    // Single write, followed by sequential addressing.
    applyStimulus(1'b0, 1'b1, 16'h0101);
    applyStimulus(1'b0, 1'b1, 16'h0202);

    // Enable gating: a matching word is ignored while en is low.
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 16'h0303);

    // Overwrite and full range, then reset overriding a matching word.
    applyStimulus(1'b0, 1'b1, 16'h02FF);
    applyStimulus(1'b0, 1'b1, 16'h0200);
    applyStimulus(1'b1, 1'b1, 16'h0155);

    // Same-value rewrite, then back-to-back overwrites where the last wins.
    applyStimulus(1'b0, 1'b1, 16'h0344);
    applyStimulus(1'b0, 1'b1, 16'h0344);
    applyStimulus(1'b0, 1'b1, 16'h0311);
    applyStimulus(1'b0, 1'b1, 16'h0322);

    // Broadcast address: this loads every channel when broadcast is
    // enabled, and loads only the channel-255 instance otherwise.
    applyStimulus(1'b0, 1'b1, 16'hFF7A);
    applyStimulus(1'b0, 1'b0, 16'hFF33);
    applyStimulus(1'b0, 1'b1, {8'(LAST_CH), 8'hC3});

    // Random traffic, biased toward addresses that some instance decodes.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 6))
        0, 1, 2: a = 8'($urandom_range(0, 3));
        3:       a = 8'hFF;
        4:       a = 8'hFE;
        default: a = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                    {a, 8'($urandom_range(0, 255))});
    end

    // Let the monitor drain the remaining predictions within a bounded
    // window.
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
